// File: rtl/cosim_mem_serializer_pkg.sv
// Shared encodings for the cosim memory serializer: region ids, size codes,
// FSM states and the region index mapping.
package cosim_mem_pkg;

  localparam logic [31:0] GLOBAL_ID   = 32'h1000;
  localparam logic [31:0] ILM_SEL     = 32'd0;
  localparam logic [31:0] DLM_SEL     = 32'd1;
  localparam logic [31:0] CORE_STRIDE = 32'h10;

  typedef enum logic [1:0] {
    SZ_1 = 2'd0,
    SZ_2 = 2'd1,
    SZ_4 = 2'd2,
    SZ_8 = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Region 0 is global memory; core c owns ILM at 1+2c and DLM at 2+2c.
  function automatic logic [31:0] region_idx(input logic [31:0] core, input logic dlm);
    return 32'd1 + (core << 1) + {31'd0, dlm};
  endfunction

  function automatic logic [2:0] last_beat(input logic [1:0] size);
    logic [2:0] r;
    case (size)
      SZ_1:    r = 3'd0;
      SZ_2:    r = 3'd1;
      SZ_4:    r = 3'd3;
      default: r = 3'd7;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cosim_mem_serializer_id_decoder.sv
// Pure combinational decode of region id + byte address + size into a
// region index, a byte offset inside that region and a range/decode error.
module cosim_id_decoder
  import cosim_mem_pkg::*;
#(
  parameter int          NUM_CORES   = 3,
  parameter logic [31:0] GLOBAL_BASE = 32'h8000_0000,
  parameter int          GLOBAL_SIZE = 1048576,
  parameter int          ILM_SIZE    = 4096,
  parameter int          DLM_SIZE    = 16384,
  parameter int          OFF_W       = 20,
  localparam int         RGN_W       = $clog2(1 + 2 * NUM_CORES)
) (
  input  logic [31:0]      i_id,
  input  logic [31:0]      i_addr,
  input  logic [1:0]       i_size,
  output logic [RGN_W-1:0] o_region,
  output logic [OFF_W-1:0] o_offset,
  output logic             o_err
);

  logic [31:0] w_core;
  logic [31:0] w_sel;
  logic [31:0] w_off32;
  logic [31:0] w_rgn;
  logic [32:0] w_limit;
  logic [32:0] w_n;
  logic [32:0] w_end;
  logic        w_known;
  logic        w_unused;

  assign w_core = i_id / CORE_STRIDE;
  assign w_sel  = i_id % CORE_STRIDE;
  assign w_n    = 33'd1 << i_size;

  always_comb begin
    w_known = 1'b0;
    w_off32 = '0;
    w_limit = '0;
    w_rgn   = '0;
    if (i_id == GLOBAL_ID) begin
      w_known = 1'b1;
      w_off32 = i_addr - GLOBAL_BASE;
      w_limit = 33'(GLOBAL_SIZE);
    end else if (w_core < 32'(NUM_CORES) && (w_sel == ILM_SEL || w_sel == DLM_SEL)) begin
      w_known = 1'b1;
      w_rgn   = region_idx(w_core, w_sel == DLM_SEL);
      if (w_sel == DLM_SEL) begin
        w_off32 = i_addr - 32'(ILM_SIZE);
        w_limit = 33'(DLM_SIZE);
      end else begin
        w_off32 = i_addr;
        w_limit = 33'(ILM_SIZE);
      end
    end
  end

  // 33-bit end check so an offset near 2^32 cannot wrap back into range.
  assign w_end    = {1'b0, w_off32} + w_n;
  assign o_err    = !w_known || (w_end > w_limit);
  assign o_region = w_rgn[RGN_W-1:0];
  assign o_offset = w_off32[OFF_W-1:0];
  assign w_unused = ^{w_rgn[31:RGN_W], w_off32[31:OFF_W]};

endmodule

// File: rtl/cosim_mem_serializer.sv
// Serializes one 1/2/4/8-byte bus request into little-endian byte beats on
// the memory model port and returns a single assembled response.
module cosim_mem_serializer
  import cosim_mem_pkg::*;
#(
  parameter int          NUM_CORES   = 3,
  parameter logic [31:0] GLOBAL_BASE = 32'h8000_0000,
  parameter int          GLOBAL_SIZE = 1048576,
  parameter int          ILM_SIZE    = 4096,
  parameter int          DLM_SIZE    = 16384,
  parameter int          OFF_W       = 20,
  localparam int         RGN_W       = $clog2(1 + 2 * NUM_CORES)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [31:0]      req_id,
  input  logic [63:0]      req_addr,
  input  logic [1:0]       req_size,
  input  logic [63:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             bd_en,
  output logic             bd_we,
  output logic [RGN_W-1:0] bd_region,
  output logic [OFF_W-1:0] bd_offset,
  output logic [7:0]       bd_wdata,
  input  logic [7:0]       bd_rdata,
  output logic [1:0]       dbg_state
);

  // Handshakes: a request transfers on the rising edge where req_valid and
  // req_ready are both high; a response transfers where rsp_valid and
  // rsp_ready are both high. rsp_* stay stable while rsp_valid waits.
  state_e           r_state;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic             r_bd_en;
  logic             r_bd_we;
  logic [RGN_W-1:0] r_region;
  logic [OFF_W-1:0] r_offset;
  logic [7:0]       r_bd_wdata;
  logic [63:0]      r_wdata;
  logic [63:0]      r_rdata;
  logic [2:0]       r_cnt;
  logic [2:0]       r_last;
  logic             r_prev_rd;
  logic [2:0]       r_prev_idx;

  logic             w_accept;
  logic             w_err;
  logic [RGN_W-1:0] w_region;
  logic [OFF_W-1:0] w_offset;
  logic [2:0]       w_cnt_nxt;
  logic             w_unused;

  // Decode looks at the request on the accepting cycle so that an error
  // response can already be registered at the accept edge.
  cosim_id_decoder #(
    .NUM_CORES  (NUM_CORES),
    .GLOBAL_BASE(GLOBAL_BASE),
    .GLOBAL_SIZE(GLOBAL_SIZE),
    .ILM_SIZE   (ILM_SIZE),
    .DLM_SIZE   (DLM_SIZE),
    .OFF_W      (OFF_W)
  ) u_dec (
    .i_id    (req_id),
    .i_addr  (req_addr[31:0]),
    .i_size  (req_size),
    .o_region(w_region),
    .o_offset(w_offset),
    .o_err   (w_err)
  );

  assign w_accept  = req_valid && r_req_ready;
  assign w_cnt_nxt = r_cnt + 3'd1;
  assign w_unused  = ^req_addr[63:32];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_bd_en     <= 1'b0;
      r_bd_we     <= 1'b0;
      r_region    <= '0;
      r_offset    <= '0;
      r_bd_wdata  <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_cnt       <= '0;
      r_last      <= '0;
      r_prev_rd   <= 1'b0;
      r_prev_idx  <= '0;
    end else begin
      // Memory returns a read byte one cycle after its beat.
      if (r_prev_rd) r_rdata[{r_prev_idx, 3'b000} +: 8] <= bd_rdata;
      r_prev_rd  <= r_bd_en && !r_bd_we;
      r_prev_idx <= r_cnt;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_rdata     <= '0;
            r_wdata     <= req_wdata;
            r_cnt       <= '0;
            r_last      <= last_beat(req_size);
            if (w_err) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state    <= ST_XFER;
              r_bd_en    <= 1'b1;
              r_bd_we    <= req_write;
              r_region   <= w_region;
              r_offset   <= w_offset;
              r_bd_wdata <= req_wdata[7:0];
            end
          end
        end
        ST_XFER: begin
          if (r_cnt == r_last) begin
            r_bd_en <= 1'b0;
            r_bd_we <= 1'b0;
            r_state <= ST_DRAIN;
          end else begin
            r_cnt      <= w_cnt_nxt;
            r_offset   <= r_offset + OFF_W'(1);
            r_bd_wdata <= r_wdata[{w_cnt_nxt, 3'b000} +: 8];
          end
        end
        ST_DRAIN: begin
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rdata;
  assign bd_en     = r_bd_en;
  assign bd_we     = r_bd_we;
  assign bd_region = r_region;
  assign bd_offset = r_offset;
  assign bd_wdata  = r_bd_wdata;
  assign dbg_state = r_state;

endmodule
